// File: rtl/priority_encoder_4to2_sync_if.sv
// Request/result bundle for the 4-to-2 priority encoder.
// The slave side is the encoder itself; the master side drives requests and consumes results.
interface priority_encoder_4to2_sync_if;
   logic [3:0] in_i;
   logic [1:0] out_o;
   logic       valid_o;
   logic       multi_o;

   modport master (
      output in_i,
      input  out_o,
      input  valid_o,
      input  multi_o
   );

   modport slave (
      input  in_i,
      output out_o,
      output valid_o,
      output multi_o
   );
endinterface

// File: rtl/priority_encoder_4to2_sync.sv
// Registered 4-to-2 priority encoder: bit 3 wins, with valid and multiple-request flags.
// Every output comes from a flop, so there is no combinational path from request to result.
module priority_encoder_4to2_sync (
   input  logic                           clk,
   input  logic                           rst_n,
   priority_encoder_4to2_sync_if.slave    bus
);

   logic [1:0] out_q;
   logic [1:0] out_d;
   logic       valid_q;
   logic       valid_d;
   logic       multi_q;
   logic       multi_d;
   logic [2:0] reqCount;

   // An empty request vector encodes to 00; consumers must qualify the index with valid.
   always_comb begin
      out_d    = 2'b00;
      reqCount = {2'b00, bus.in_i[0]} + {2'b00, bus.in_i[1]}
               + {2'b00, bus.in_i[2]} + {2'b00, bus.in_i[3]};
      if (bus.in_i[3]) begin
         out_d = 2'b11;
      end else if (bus.in_i[2]) begin
         out_d = 2'b10;
      end else if (bus.in_i[1]) begin
         out_d = 2'b01;
      end
      valid_d = |bus.in_i;
      multi_d = (reqCount >= 3'd2);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q   <= 2'b00;
         valid_q <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
         multi_q <= multi_d;
      end
   end

   assign bus.out_o   = out_q;
   assign bus.valid_o = valid_q;
   assign bus.multi_o = multi_q;

endmodule

// File: tb/tb_priority_encoder_4to2_sync.sv
// Directed self-checking bench for priority_encoder_4to2_sync.
// Results are compared as packed {out, valid, multi} against hand-computed values.
module tb_priority_encoder_4to2_sync;

   logic clk;
   logic rstN;
   int   testsRun;
   int   testsFailed;
   logic [3:0] expTable [16];

   priority_encoder_4to2_sync_if peIf ();

   priority_encoder_4to2_sync dut (
      .clk   (clk),
      .rst_n (rstN),
      .bus   (peIf.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got {out,valid,multi}=%b, expected %b", tag, observed, expected);
      end
   endtask

   // Inputs change on the falling edge; results are read 1 time unit after the rising edge.
   task automatic applyStimulus(input logic [3:0] req, input logic rstVal);
      @(negedge clk);
      peIf.in_i = req;
      rstN      = rstVal;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] observed();
      return {peIf.out_o, peIf.valid_o, peIf.multi_o};
   endfunction

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      peIf.in_i   = 4'b1111;
      rstN        = 1'b0;

      expTable = '{4'b0000, 4'b0010, 4'b0110, 4'b0111,
                   4'b1010, 4'b1011, 4'b1011, 4'b1011,
                   4'b1110, 4'b1111, 4'b1111, 4'b1111,
                   4'b1111, 4'b1111, 4'b1111, 4'b1111};

      applyStimulus(4'b1111, 1'b0);
      checkOutput("reset_edge1", observed(), 4'b0000);
      applyStimulus(4'b1111, 1'b0);
      checkOutput("reset_edge2", observed(), 4'b0000);
      applyStimulus(4'b1111, 1'b1);
      checkOutput("reset_release", observed(), 4'b1111);

      applyStimulus(4'b0001, 1'b1);
      checkOutput("onehot_0001", observed(), 4'b0010);
      applyStimulus(4'b0010, 1'b1);
      checkOutput("onehot_0010", observed(), 4'b0110);
      applyStimulus(4'b0100, 1'b1);
      checkOutput("onehot_0100", observed(), 4'b1010);
      applyStimulus(4'b1000, 1'b1);
      checkOutput("onehot_1000", observed(), 4'b1110);

      applyStimulus(4'b0011, 1'b1);
      checkOutput("prio_0011", observed(), 4'b0111);
      applyStimulus(4'b0110, 1'b1);
      checkOutput("prio_0110", observed(), 4'b1011);
      applyStimulus(4'b1111, 1'b1);
      checkOutput("prio_1111", observed(), 4'b1111);
      applyStimulus(4'b1001, 1'b1);
      checkOutput("prio_1001", observed(), 4'b1111);

      applyStimulus(4'b0000, 1'b1);
      checkOutput("empty_0000", observed(), 4'b0000);
      applyStimulus(4'b0001, 1'b1);
      checkOutput("lowest_0001", observed(), 4'b0010);

      // Back-to-back sweep; the mid-cycle read proves the old result holds until the edge.
      for (int v = 0; v < 16; v++) begin
         logic [3:0] prevExp;
         prevExp = (v == 0) ? 4'b0010 : expTable[v-1];
         @(negedge clk);
         peIf.in_i = 4'(v);
         #1;
         checkOutput($sformatf("hold_%0d", v), observed(), prevExp);
         @(posedge clk);
         #1;
         checkOutput($sformatf("exh_%0d", v), observed(), expTable[v]);
      end

      applyStimulus(4'b0001, 1'b1);
      applyStimulus(4'b0010, 1'b1);
      applyStimulus(4'b0100, 1'b1);
      applyStimulus(4'b1000, 1'b1);
      checkOutput("sweep_before_reset", observed(), 4'b1110);
      applyStimulus(4'b1000, 1'b0);
      checkOutput("midstream_reset", observed(), 4'b0000);
      applyStimulus(4'b0100, 1'b1);
      checkOutput("resume_0100", observed(), 4'b1010);
      applyStimulus(4'b0101, 1'b1);
      checkOutput("resume_0101", observed(), 4'b1011);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/priority_encoder_4to2_sync.md
# priority_encoder_4to2_sync

Registered 4-to-2 priority encoder with the highest bit having highest priority. Each clock it samples a 4-bit request vector and outputs the 2-bit index of the highest-numbered asserted bit. It also outputs a valid flag and a multiple-request flag. It sits in the control path wherever one of four request lines must be reduced to a binary index, such as an arbiter front end or an interrupt-source decoder.

## Interface
Module name: `priority_encoder_4to2_sync`. One clock; reset is synchronous and active-low.

Parameters:
- None. Width is fixed at 4 inputs and 2 output bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in  input  4  request vector; bit 3 highest priority, bit 0 lowest
- out  output  2  registered index of the highest asserted request bit
- valid  output  1  registered; 1 when at least one bit of `in` was set at the last sample
- multi  output  1  registered; 1 when two or more bits of `in` were set at the last sample

## Operation
Encoding, evaluated on the sampled `in`:
- in[3]=1 → out=11
- else in[2]=1 → out=10
- else in[1]=1 → out=01
- else in[0]=1 → out=00
- in=0000 → out=00, valid=0. Downstream must qualify `out` with `valid`. Outputs are never X.

Flags:
- valid = OR of in[3:0].
- multi = 1 when the population count of `in` is ≥2. Lower set bits never change `out`.

General:
- `in` must be synchronous to `clk`; there is no internal synchronizer.
- No other state exists. Each output depends only on the most recent sample of `in`.

## Timing
- All outputs are registered and update on the rising edge of `clk`.
- Latency is 1 cycle: `in` sampled at edge N appears on out/valid/multi after edge N.
- Throughput is one new encode per cycle, with no stalls and no handshake.
- Reset: rst_n=0 at a rising edge forces out=00, valid=0, multi=0 at that edge. `in` is ignored while rst_n is low.
- Reset deasserted: the first edge with rst_n=1 samples `in` normally, with no extra dead cycle.
- Reset mid-stream: the in-flight result is discarded. Outputs read 00/0/0 on the cycle after the reset edge.
- Outputs are glitch-free, because no combinational path runs from `in` to any output.

## Test plan
- Reset: hold rst_n=0 for 2 edges with in=1111 → out=00, valid=0, multi=0. Release → the next edge gives out=11, valid=1, multi=1.
- One-hot sweep: in=0001, 0010, 0100, 1000 on consecutive cycles → out=00, 01, 10, 11 one cycle later, each with valid=1 and multi=0.
- Priority cases:
  - in=0011 → out=01, multi=1
  - in=0110 → out=10, multi=1
  - in=1111 → out=11, multi=1
  - in=1001 → out=11, multi=1
- Empty: in=0000 → out=00, valid=0, multi=0. Compare against in=0001 → out=00, valid=1, which distinguishes the two cases.
- Exhaustive: all 16 values of `in` applied back-to-back → every cycle's out/valid/multi match the reference model delayed by exactly one cycle.
- Mid-stream reset: run the sweep, then pulse rst_n=0 for one edge → outputs read 00/0/0 for that cycle. Correct encoding resumes on the next edge.
